// File: rtl/mem_bridge.sv
// mem_bridge: turns the multicycle controller's held read/write strobes into a
// single request/acknowledge transaction on the external memory bus, stalling
// the controller until the bus completes.
// Optional feature macro: MEM_BRIDGE_TIMEOUT_EN -- adds a REQ-state watchdog
// that abandons a transaction after TIMEOUT_CYCLES cycles without bus_ack and
// pulses bus_err. With the macro undefined, REQ waits for bus_ack forever.
//
// Handshake: the controller raises mem_read/mem_write and holds them while
// stall = 1; the transaction is complete in the cycle stall drops (DONE).
// On the bus side bus_req stays high with stable bus_we/bus_addr/bus_wdata
// until the cycle memory returns its one-cycle bus_ack; bus_rdata is sampled
// in that same cycle.
module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic [1:0]  o_dbg_state
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYCLES must be in 1..256");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        w_strobe;
  logic        w_start;
  logic        w_timeout;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  assign w_strobe = mem_read | mem_write;
  assign w_start  = (r_state == ST_IDLE) && w_strobe;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] LP_LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       r_timed_out;

  // Timeout fires only when no ack arrives, so a coincident ack wins.
  assign w_timeout = (r_state == ST_REQ) && !bus_ack && (r_cnt == LP_LAST_CNT);

  // Watchdog: clear on entry to REQ, count each REQ cycle without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 8'd0;
    end else if (w_start) begin
      r_cnt <= 8'd0;
    end else if ((r_state == ST_REQ) && !bus_ack) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Remember whether the REQ -> DONE transition was caused by the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timed_out <= 1'b0;
    end else if (r_state == ST_REQ) begin
      r_timed_out <= w_timeout;
    end else if (r_state == ST_DONE) begin
      r_timed_out <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    bus_req      = 1'b0;
    rdata_valid  = 1'b0;
    bus_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_strobe;
        if (w_strobe) begin
          w_next_state = ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || w_timeout) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        rdata_valid  = !r_we;
`ifdef MEM_BRIDGE_TIMEOUT_EN
        bus_err      = r_timed_out;
`endif
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the request in IDLE so the bus side is immune to datapath changes.
  // Write wins when both strobes are high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_start) begin
      r_we    <= mem_write;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Read data register: updated only by a completed or timed-out read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if ((r_state == ST_REQ) && !r_we) begin
      if (bus_ack) begin
        r_rdata <= bus_rdata;
      end else if (w_timeout) begin
        r_rdata <= 32'd0;
      end
    end
  end

  assign bus_we      = r_we;
  assign bus_addr    = r_addr;
  assign bus_wdata   = r_wdata;
  assign rdata       = r_rdata;
  assign o_dbg_state = r_state;

endmodule
